// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm.
// One bit is processed per clock; results are handed off with a valid/ready pair.
module bin_to_bcd_conv #(
  parameter int unsigned W  = 8,
  parameter int unsigned ND = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [W-1:0]      inBin,
  output logic              outValid,
  input  logic              outReady,
  output logic [4*ND-1:0]   outBcd,
  output logic              busy
);

  localparam int unsigned BW = 4 * ND;
  localparam int unsigned CW = $clog2(W + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Refuse to build a converter whose digit count cannot hold the full input range.
  generate
    if (pow10(ND) < (64'd1 << W)) begin : g_range_check
      $error("bin_to_bcd_conv: ND BCD digits cannot represent W-bit inputs");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   bin_q;
  logic [BW-1:0]  bcd_q;
  logic [CW-1:0]  cnt_q;
  logic [BW-1:0]  adj;
  logic [BW-1:0]  step_bcd;
  logic [W-1:0]   step_bin;
  logic           last_step;

  // One double-dabble step: correct digits >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {step_bcd, step_bin} = {adj, bin_q} << 1;
  end

  assign last_step = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (inValid)   state_next = SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (outReady)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake flags, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      outBcd   <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      inReady  <= (state_next == IDLE);
      outValid <= (state_next == DONE);
      busy     <= (state_next != IDLE);
      unique case (state)
        IDLE: begin
          if (inValid) begin
            bin_q <= inBin;
            bcd_q <= '0;
            cnt_q <= CW'(W);
          end
        end
        SHIFT: begin
          bin_q <= step_bin;
          bcd_q <= step_bcd;
          cnt_q <= cnt_q - CW'(1);
          if (last_step) outBcd <= step_bcd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Self-checking bench for bin_to_bcd_conv: directed corner cases, handshake
// behaviour, mid-conversion reset, an exhaustive sweep and randomized operands.
module tb_bin_to_bcd_conv;

  localparam int unsigned W  = 8;
  localparam int unsigned ND = 3;
  localparam int unsigned BW = 4 * ND;

  logic          clk;
  logic          resetN;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inBin;
  logic          outValid;
  logic          outReady;
  logic [BW-1:0] outBcd;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bin_to_bcd_conv #(.W(W), .ND(ND)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .inValid  (inValid),
    .inReady  (inReady),
    .inBin    (inBin),
    .outValid (outValid),
    .outReady (outReady),
    .outBcd   (outBcd),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal reference: extract base-10 digits with integer division.
  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(ND); i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Starts a conversion from IDLE and waits (bounded) for outValid; no checks here.
  task automatic convert(input logic [W-1:0] v, input bit poke, output int lat, output bit timeout);
    inValid = 1'b1;
    inBin   = v;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inBin   = W'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (poke && lat == 2) begin inValid = 1'b1; inBin = W'(7); end
      if (poke && lat == 5) inValid = 1'b0;
    end while (!outValid && lat < 40);
    timeout = !outValid;
  endtask

  task automatic release_result();
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; inValid = 1'b0; outReady = 1'b0; inBin = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (outBcd !== '0) begin errors++; $display("FAIL reset_outBcd got=%h exp=000", outBcd); end
  endtask

  task automatic test_known();
    int unsigned vals[4] = '{0, 255, 99, 100};
    int lat; bit to;
    foreach (vals[k]) begin
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL known_ready_before v=%0d got=%b exp=1", vals[k], inReady); end
      convert(W'(vals[k]), 1'b0, lat, to);
      checks++; if (to || lat != int'(W)) begin errors++; $display("FAIL known_latency v=%0d got=%0d exp=%0d", vals[k], lat, W); end
      checks++; if (outBcd !== ref_bcd(vals[k])) begin errors++; $display("FAIL known_value v=%0d got=%h exp=%h", vals[k], outBcd, ref_bcd(vals[k])); end
      checks++; if (busy !== 1'b1 || inReady !== 1'b0) begin errors++; $display("FAIL known_done_flags v=%0d busy=%b inReady=%b exp busy=1 inReady=0", vals[k], busy, inReady); end
      release_result();
      checks++; if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL known_release v=%0d outValid=%b inReady=%b busy=%b exp 0/1/0", vals[k], outValid, inReady, busy); end
      checks++; if (outBcd !== ref_bcd(vals[k])) begin errors++; $display("FAIL known_retain v=%0d got=%h exp=%h", vals[k], outBcd, ref_bcd(vals[k])); end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    convert(W'(37), 1'b0, lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got=timeout exp=outValid"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (outValid !== 1'b1 || outBcd !== 12'h037) begin errors++; $display("FAIL bp_hold cycle=%0d outValid=%b outBcd=%h exp 1/037", c, outValid, outBcd); end
    end
    release_result();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL bp_release outValid=%b inReady=%b exp 0/1", outValid, inReady); end
  endtask

  task automatic test_busy_input();
    int lat; bit to;
    convert(W'(200), 1'b1, lat, to);
    checks++; if (to || outBcd !== 12'h200) begin errors++; $display("FAIL busy_input got=%h exp=200", outBcd); end
    release_result();
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL busy_input_idle busy=%b inReady=%b exp 0/1", busy, inReady); end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    inValid = 1'b1; inBin = W'(123);
    @(posedge clk); @(negedge clk);
    inValid = 1'b0;
    for (int s = 0; s < 3; s++) begin @(posedge clk); @(negedge clk); end
    resetN = 1'b0;
    @(posedge clk); @(negedge clk);
    resetN = 1'b1;
    checks++; if (outBcd !== '0 || outValid !== 1'b0) begin errors++; $display("FAIL mid_reset_out outBcd=%h outValid=%b exp 000/0", outBcd, outValid); end
    checks++; if (inReady !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_flags inReady=%b busy=%b exp 1/0", inReady, busy); end
    outReady = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); @(negedge clk);
      if (outValid) pulses++;
    end
    outReady = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_reset_no_result got=%0d pulses exp=0", pulses); end
  endtask

  task automatic test_sweep();
    int acc, prev_acc, guard;
    outReady = 1'b1;
    inValid  = 1'b1;
    inBin    = '0;
    prev_acc = 0;
    for (int v = 0; v < (1 << W); v++) begin
      guard = 0;
      do begin @(posedge clk); @(negedge clk); guard++; end while (inReady && guard < 20);
      acc = cyc;
      inBin = W'($urandom);
      guard = 0;
      do begin @(posedge clk); @(negedge clk); guard++; end while (!outValid && guard < 40);
      checks++; if (!outValid || cyc - acc != int'(W)) begin errors++; $display("FAIL sweep_latency v=%0d got=%0d exp=%0d", v, cyc - acc, W); end
      checks++; if (outBcd !== ref_bcd(v)) begin errors++; $display("FAIL sweep_value v=%0d got=%h exp=%h", v, outBcd, ref_bcd(v)); end
      if (v > 0) begin
        checks++; if (acc - prev_acc != int'(W) + 2) begin errors++; $display("FAIL sweep_spacing v=%0d got=%0d exp=%0d", v, acc - prev_acc, W + 2); end
      end
      prev_acc = acc;
      if (v == (1 << W) - 1) inValid = 1'b0;
      else inBin = W'(v + 1);
    end
    @(posedge clk); @(negedge clk);
    outReady = 1'b0;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL sweep_end_idle got=%b exp=1", inReady); end
  endtask

  task automatic test_random();
    int lat; bit to;
    logic [W-1:0] v;
    int hold;
    for (int n = 0; n < 20; n++) begin
      v = W'($urandom);
      convert(v, 1'b0, lat, to);
      checks++; if (to || outBcd !== ref_bcd(int'(v))) begin errors++; $display("FAIL random_value v=%0d got=%h exp=%h", v, outBcd, ref_bcd(int'(v))); end
      hold = int'($urandom_range(0, 3));
      for (int c = 0; c < hold; c++) begin @(posedge clk); @(negedge clk); end
      checks++; if (outValid !== 1'b1 || outBcd !== ref_bcd(int'(v))) begin errors++; $display("FAIL random_hold v=%0d outValid=%b outBcd=%h", v, outValid, outBcd); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_backpressure();
    test_busy_input();
    test_mid_reset();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_conv.md
BIN_TO_BCD_CONV -- requirements
Module: bin_to_bcd_conv

Interface
REQ-001 The block SHALL be parameterised by W, default 8, giving the binary input width in bits.
REQ-002 The block SHALL be parameterised by ND, default 3, giving the number of BCD output digits.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetN  input  1  synchronous active-low reset.
REQ-006 inValid  input  1  inBin holds an operand to convert.
REQ-007 inReady  output  1  block accepts an operand this cycle.
REQ-008 inBin  input  W  unsigned binary operand.
REQ-009 outValid  output  1  outBcd holds a finished result.
REQ-010 outReady  output-side input  1  consumer takes the result this cycle.
REQ-011 outBcd  output  4*ND  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is least significant.
REQ-012 busy  output  1  high in SHIFT and DONE states.

Function
REQ-013 The block SHALL implement the states IDLE, SHIFT and DONE; reset SHALL enter IDLE.
REQ-014 inReady SHALL be 1 only in IDLE; outValid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on the edge where IDLE, inValid=1 and inReady=1 hold.
- On acceptance: binary shift register := inBin; BCD register := 0; counter := W; next state SHIFT.
REQ-016 Each SHIFT edge SHALL perform one double-dabble step:
- add 3 to every BCD digit whose value is >= 5;
- shift {BCD, binary} left one bit, so the binary MSB enters BCD bit 0;
- decrement the counter.
REQ-017 On the SHIFT edge that brings the counter to 0, the block SHALL load the BCD result into outBcd and enter DONE.
REQ-018 outValid SHALL rise exactly W clock edges after the acceptance edge (8 for the default W).
REQ-019 In DONE, outBcd and outValid SHALL hold unchanged until an edge with outReady=1; that edge SHALL return the FSM to IDLE.
REQ-020 No operand SHALL be accepted on the DONE-to-IDLE edge; the earliest next acceptance is the following edge.
REQ-021 Back-to-back throughput SHALL therefore be one conversion per W+2 cycles when outReady is held at 1.
REQ-022 inValid and inBin SHALL be ignored outside IDLE; inBin SHALL need to be stable only on the acceptance edge.
REQ-023 outReady SHALL be ignored outside DONE.
REQ-024 outBcd SHALL retain the last result after leaving DONE and SHALL change only on the edge that enters DONE.
REQ-025 Every output digit SHALL be in 0..9; the value of outBcd SHALL equal inBin for all inputs 0..2^W-1.
REQ-026 The block SHALL raise an elaboration error if 10^ND < 2^W.
REQ-027 The counter SHALL be ceil(log2(W+1)) bits wide and SHALL not wrap; the SHIFT state SHALL never execute more than W steps.

Reset
REQ-028 On any clock edge with resetN=0, the block SHALL force: state=IDLE, outBcd=0, outValid=0, busy=0, internal registers=0.
REQ-029 inReady SHALL read 1 in the first cycle after reset is released.
REQ-030 Reset asserted in SHIFT or DONE SHALL discard the conversion in progress, and no outValid pulse SHALL follow.

Verification
REQ-031 Zero operand: inBin=0 accepted -> outValid after 8 edges, outBcd=12'h000.
REQ-032 Full scale: inBin=255 -> outBcd=12'h255 after 8 edges.
- Also inBin=99 -> 12'h099; inBin=100 -> 12'h100.
REQ-033 Backpressure: outReady=0 for 5 cycles in DONE -> outBcd and outValid stable; return to IDLE on the first edge with outReady=1; inReady=1 the following cycle.
REQ-034 Busy input: inValid=1 with inBin=7 pulsed during SHIFT of a conversion of 200 -> result 12'h200, the 7 is not accepted.
REQ-035 Mid-operation reset: resetN=0 for one edge at SHIFT step 4 of inBin=123 -> outBcd=0, outValid=0, inReady=1 next cycle, and no result emitted.
REQ-036 Exhaustive sweep: inBin=0..255 with outReady=1 -> each outBcd matches a decimal reference model, with W+2-cycle spacing.
